// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// FSM encoding, arrow direction/key codes and small helpers.
package keypad_scan_pkg;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [1:0] ARROW_UP    = 2'd0;
  localparam logic [1:0] ARROW_DOWN  = 2'd1;
  localparam logic [1:0] ARROW_LEFT  = 2'd2;
  localparam logic [1:0] ARROW_RIGHT = 2'd3;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_DOWN  = 4'd9;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } arrow_t;

  function automatic arrow_t arrow_lookup(input logic [3:0] code);
    arrow_t a;
    a = '{hit: 1'b0, dir: ARROW_UP};
    case (code)
      KEY_UP:    a = '{hit: 1'b1, dir: ARROW_UP};
      KEY_DOWN:  a = '{hit: 1'b1, dir: ARROW_DOWN};
      KEY_LEFT:  a = '{hit: 1'b1, dir: ARROW_LEFT};
      KEY_RIGHT: a = '{hit: 1'b1, dir: ARROW_RIGHT};
      default:   a = '{hit: 1'b0, dir: ARROW_UP};
    endcase
    return a;
  endfunction

  // Lowest-index active-low row wins.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd3;
    if (!rows[2]) r = 2'd2;
    if (!rows[1]) r = 2'd1;
    if (!rows[0]) r = 2'd0;
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Column-period divider for the keypad scanner.
// scan_tick marks the last clock of each SCAN_DIV-clock period.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 10_000
) (
  input  logic clk,
  input  logic reset,
  output logic scan_tick
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign scan_tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Single-key, no rollover; arrow keys also report a direction.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10_000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] arrow,
  output logic       arrow_valid
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [3:0]    sync1;
  logic [3:0]    row_s;
  logic [1:0]    state;
  logic [1:0]    col;
  logic [1:0]    lat_row;
  logic [CW-1:0] cnt;
  logic          scan_tick;
  logic          row_low;
  logic          done;
  arrow_t        hit;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .scan_tick (scan_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      row_s <= 4'hF;
    end else begin
      sync1 <= key_row;
      row_s <= sync1;
    end
  end

  assign row_low  = ~row_s[lat_row];
  assign done     = (cnt >= DB_MAX);
  assign hit      = arrow_lookup({lat_row, col});
  assign key_col  = ~(4'b0001 << col);
  assign key_held = (state == S_HELD) || (state == S_RELEASE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_SCAN;
      col         <= 2'd0;
      lat_row     <= 2'd0;
      cnt         <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      arrow       <= ARROW_DOWN;
      arrow_valid <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      arrow_valid <= 1'b0;
      unique case (state)
        S_SCAN: begin
          if (scan_tick) begin
            if (&row_s) begin
              col <= col + 2'd1;
            end else begin
              lat_row <= low_row(row_s);
              cnt     <= C_ONE;
              state   <= S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (done) begin
            key_code  <= {lat_row, col};
            key_valid <= 1'b1;
            if (hit.hit) begin
              arrow       <= hit.dir;
              arrow_valid <= 1'b1;
            end
            cnt   <= '0;
            state <= S_HELD;
          end else if (scan_tick) begin
            if (row_low) begin
              cnt <= cnt + C_ONE;
            end else begin
              cnt   <= '0;
              state <= S_SCAN;
            end
          end
        end
        S_HELD: begin
          if (scan_tick && !row_low) begin
            cnt   <= C_ONE;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (done) begin
            cnt   <= '0;
            col   <= col + 2'd1;
            state <= S_SCAN;
          end else if (scan_tick) begin
            if (!row_low) begin
              cnt <= cnt + C_ONE;
            end else begin
              cnt   <= '0;
              state <= S_HELD;
            end
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a keypad matrix model.
// Expected key events are queued at press time and popped on key_valid.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] arrow;
  logic       arrow_valid;

  logic [15:0] pressed = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] code;
    logic       av;
    logic [1:0] arrow;
  } exp_t;

  typedef struct {
    logic [3:0] code;
    int         hold;
    logic       av;
    logic [1:0] arrow;
  } vec_t;

  exp_t q[$];
  vec_t vecs[8];
  logic prev_kv = 1'b0;

  keypad_scan #(
    .SCAN_DIV       (8),
    .DEBOUNCE_TICKS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .arrow       (arrow),
    .arrow_valid (arrow_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c])
          key_row[r] = 1'b0;
  end

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (arrow_valid && !key_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL arrow_valid_alone: got 1 expected 0");
      end
      if (key_valid) begin
        check("kv_single_pulse", prev_kv, 0);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_key_valid: code %0d expected none", key_code);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("key_code", key_code, e.code);
          check("arrow_valid", arrow_valid, e.av);
          check("arrow", arrow, e.arrow);
        end
      end
      prev_kv = key_valid;
    end else begin
      prev_kv = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_release();
    for (int i = 0; i < 300 && key_held; i++) step(1);
    check("release_timeout", key_held, 0);
  endtask

  task automatic wait_col(input logic [3:0] target);
    for (int i = 0; i < 100 && key_col == target; i++) step(1);
    for (int i = 0; i < 100 && key_col != target; i++) step(1);
    check("col_align", key_col, target);
  endtask

  task automatic press_release(input vec_t v);
    q.push_back('{code: v.code, av: v.av, arrow: v.arrow});
    pressed[v.code] = 1'b1;
    step(v.hold);
    check("held_during_press", key_held, 1);
    check("accepted_in_time", q.size(), 0);
    pressed[v.code] = 1'b0;
    wait_release();
    step(10);
  endtask

  initial begin
    vecs[0] = '{code: 4'd5,  hold: 80, av: 1'b0, arrow: 2'd1};
    vecs[1] = '{code: 4'd6,  hold: 80, av: 1'b1, arrow: 2'd3};
    vecs[2] = '{code: 4'd15, hold: 80, av: 1'b0, arrow: 2'd3};
    vecs[3] = '{code: 4'd9,  hold: 80, av: 1'b1, arrow: 2'd1};
    vecs[4] = '{code: 4'd1,  hold: 80, av: 1'b1, arrow: 2'd0};
    vecs[5] = '{code: 4'd0,  hold: 80, av: 1'b0, arrow: 2'd0};
    vecs[6] = '{code: 4'd4,  hold: 80, av: 1'b1, arrow: 2'd2};
    vecs[7] = '{code: 4'd12, hold: 80, av: 1'b0, arrow: 2'd2};

    reset = 1'b0;
    step(3);
    check("rst_key_col", key_col, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    check("rst_arrow", arrow, 1);
    check("rst_arrow_valid", arrow_valid, 0);
    reset = 1'b1;

    // Idle scan: column advances every 8 clocks.
    step(4);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << (k % 4));
      check("idle_key_col", key_col, ec);
      step(8);
    end

    foreach (vecs[i]) press_release(vecs[i]);

    // Bounce on code 6: low 28, high 8, then steady low.
    wait_col(4'b1011);
    q.push_back('{code: 4'd6, av: 1'b1, arrow: 2'd3});
    pressed[6] = 1'b1;
    step(28);
    pressed[6] = 1'b0;
    step(8);
    check("bounce_no_early_valid", q.size(), 1);
    pressed[6] = 1'b1;
    step(80);
    check("bounce_accepted", q.size(), 0);
    check("bounce_held", key_held, 1);
    pressed[6] = 1'b0;
    wait_release();
    step(10);

    // Hold 9, add 1 on the same column: no second pulse.
    q.push_back('{code: 4'd9, av: 1'b1, arrow: 2'd1});
    pressed[9] = 1'b1;
    step(80);
    check("hold9_accepted", q.size(), 0);
    pressed[1] = 1'b1;
    step(80);
    check("hold9_code_kept", key_code, 9);
    check("hold9_still_held", key_held, 1);
    pressed[9] = 1'b0;
    pressed[1] = 1'b0;
    wait_release();
    step(10);
    press_release('{code: 4'd1, hold: 80, av: 1'b1, arrow: 2'd0});

    // Reset mid-debounce of code 4 aborts silently.
    wait_col(4'b1110);
    pressed[4] = 1'b1;
    step(12);
    reset = 1'b0;
    step(1);
    check("abort_key_valid", key_valid, 0);
    check("abort_arrow", arrow, 1);
    check("abort_key_col", key_col, 4'b1110);
    pressed[4] = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    check("post_rst_key_col", key_col, 4'b1110);
    check("post_rst_key_held", key_held, 0);
    step(100);
    check("post_rst_key_code", key_code, 0);
    check("post_rst_no_pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
